// File: rtl/tlul_mem_device.sv
// TL-UL single-cycle memory device: DEPTH x 32-bit words with byte-masked writes.
// Define TLUL_MEM_DEVICE_ERR_EN to report request errors on d_error.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_mem_device #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o
);

  localparam int unsigned IW       = $clog2(DEPTH);
  localparam logic [2:0]  PUT_FULL = 3'd0;
  localparam logic [2:0]  PUT_PART = 3'd1;
  localparam logic [2:0]  GET      = 3'd4;
  localparam logic [2:0]  ACK      = 3'd0;
  localparam logic [2:0]  ACK_DATA = 3'd1;

  typedef enum logic {IDLE, RSP} state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lsb[0];
      default: misaligned = |lsb;
    endcase
  endfunction

  // Mask a PutFullData must carry to cover exactly the addressed bytes.
  function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    size_mask = 4'b0001 << lsb;
      2'd1:    size_mask = 4'b0011 << lsb;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  state_e      state;
  logic        vld_p1;
  logic [2:0]  op_p1;
  logic [1:0]  size_p1;
  logic [7:0]  src_p1;
  logic [31:0] data_p1;
  logic        err_p1;
  logic [31:0] mem [DEPTH];

  // p0: request decode and error classification
  logic          a_ready;
  logic          acc_p0;
  logic [31:0]   off_p0;
  logic [IW-1:0] idx_p0;
  logic          in_range_p0;
  logic          is_get_p0;
  logic          is_put_p0;
  logic          err_p0;
  logic          err_rsp_p0;
  logic [2:0]    op_p0;
  logic [31:0]   data_p0;
  logic          unused_p0;

  assign a_ready     = !vld_p1 || tl_i.d_ready;
  assign acc_p0      = tl_i.a_valid && a_ready;
  assign off_p0      = tl_i.a_address - BASE_ADDR;
  assign idx_p0      = off_p0[IW+1:2];
  assign in_range_p0 = (off_p0 >> (IW + 2)) == 32'd0;
  assign is_get_p0   = tl_i.a_opcode == GET;
  assign is_put_p0   = (tl_i.a_opcode == PUT_FULL) || (tl_i.a_opcode == PUT_PART);
  assign err_p0      = !(is_get_p0 || is_put_p0) || !in_range_p0 || (tl_i.a_size == 2'd3)
                     || misaligned(tl_i.a_size, off_p0[1:0])
                     || ((tl_i.a_opcode == PUT_FULL)
                         && (tl_i.a_mask != size_mask(tl_i.a_size, off_p0[1:0])))
                     || (is_put_p0 && (tl_i.a_mask == 4'h0));
  assign op_p0       = is_get_p0 ? ACK_DATA : ACK;
  assign data_p0     = (is_get_p0 && !err_p0) ? mem[idx_p0] : 32'h0;
  assign unused_p0   = ^{tl_i.a_param, tl_i.a_user};

`ifdef TLUL_MEM_DEVICE_ERR_EN
  assign err_rsp_p0 = err_p0;
`else
  assign err_rsp_p0 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
    end else if (acc_p0 && is_put_p0 && !err_p0) begin
      for (int b = 0; b < 4; b++) begin
        if (tl_i.a_mask[b]) mem[idx_p0][8*b +: 8] <= tl_i.a_data[8*b +: 8];
      end
    end
  end

  // p1: registered D-channel response, held until handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      op_p1   <= 3'd0;
      size_p1 <= 2'd0;
      src_p1  <= 8'd0;
      data_p1 <= 32'h0;
      err_p1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_p0) begin
            state   <= RSP;
            vld_p1  <= 1'b1;
            op_p1   <= op_p0;
            size_p1 <= tl_i.a_size;
            src_p1  <= tl_i.a_source;
            data_p1 <= data_p0;
            err_p1  <= err_rsp_p0;
          end
        end
        RSP: begin
          if (acc_p0) begin
            vld_p1  <= 1'b1;
            op_p1   <= op_p0;
            size_p1 <= tl_i.a_size;
            src_p1  <= tl_i.a_source;
            data_p1 <= data_p0;
            err_p1  <= err_rsp_p0;
          end else if (tl_i.d_ready) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign tl_o = '{d_valid:  vld_p1,
                  d_opcode: op_p1,
                  d_param:  3'd0,
                  d_size:   size_p1,
                  d_source: src_p1,
                  d_sink:   1'b0,
                  d_data:   data_p1,
                  d_user:   16'd0,
                  d_error:  err_p1,
                  a_ready:  a_ready};

endmodule

// File: tb/tb_tlul_mem_device.sv
// Directed bench for tlul_mem_device: writes, partial writes, errors, back-pressure,
// streaming reads and reset during a pending response.
module tb_tlul_mem_device;
  import tlul_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  tl_d2h_t rsp;
  int      tests = 0;
  int      fails = 0;

`ifdef TLUL_MEM_DEVICE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  tlul_mem_device #(.DEPTH(16), .BASE_ADDR(32'h0)) dut (
    .clk  (clk),
    .rst  (rst),
    .tl_i (tl_i),
    .tl_o (tl_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_user    = 16'd0;
  endtask

  // One request with d_ready=1; returns the D beat seen one cycle after accept.
  task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                      output tl_d2h_t r);
    int n;
    tl_i.d_ready = 1'b1;
    drive(op, addr, size, mask, data, src);
    #1;
    n = 0;
    while (!tl_o.a_ready && n < 20) begin
      tick();
      n++;
    end
    if (!tl_o.a_ready) chk("a_ready_timeout", 32'(tl_o.a_ready), 32'd1);
    @(posedge clk);
    #1;
    tl_i.a_valid = 1'b0;
    r = tl_o;
    chk("d_valid_after_accept", 32'(tl_o.d_valid), 32'd1);
  endtask

  task automatic chk_rsp(input string tag, input tl_d2h_t r, input logic [2:0] op,
                         input logic [7:0] src, input logic [1:0] size,
                         input logic [31:0] data, input logic err);
    chk({tag, "_opcode"}, 32'(r.d_opcode), 32'(op));
    chk({tag, "_source"}, 32'(r.d_source), 32'(src));
    chk({tag, "_size"}, 32'(r.d_size), 32'(size));
    chk({tag, "_data"}, r.d_data, data);
    chk({tag, "_error"}, 32'(r.d_error), 32'(err));
    chk({tag, "_zero_fields"}, 32'({r.d_param, r.d_sink, r.d_user}), 32'd0);
  endtask

  function automatic logic [31:0] exp_word(input int i);
    case (i)
      2:       exp_word = 32'hDEAABEEF;
      3:       exp_word = 32'h00007700;
      default: exp_word = 32'h0;
    endcase
  endfunction

  initial begin
    tl_i = '0;
    #12;
    chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    chk("rst_d_data", tl_o.d_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    chk("post_rst_d_valid", 32'(tl_o.d_valid), 32'd0);

    xact(3'd0, 32'h8, 2'd2, 4'hF, 32'hDEADBEEF, 8'd1, rsp);
    chk_rsp("put_full", rsp, 3'd0, 8'd1, 2'd2, 32'h0, 1'b0);
    xact(3'd4, 32'h8, 2'd2, 4'h0, 32'h0, 8'd2, rsp);
    chk_rsp("get_full", rsp, 3'd1, 8'd2, 2'd2, 32'hDEADBEEF, 1'b0);

    xact(3'd1, 32'h8, 2'd2, 4'h4, 32'h00AA0000, 8'd3, rsp);
    chk_rsp("put_part", rsp, 3'd0, 8'd3, 2'd2, 32'h0, 1'b0);
    xact(3'd4, 32'h8, 2'd2, 4'h1, 32'h0, 8'd4, rsp);
    chk_rsp("get_part", rsp, 3'd1, 8'd4, 2'd2, 32'hDEAABEEF, 1'b0);

    xact(3'd0, 32'hD, 2'd0, 4'h2, 32'h00007700, 8'd5, rsp);
    chk_rsp("put_byte", rsp, 3'd0, 8'd5, 2'd0, 32'h0, 1'b0);
    xact(3'd4, 32'hC, 2'd2, 4'hF, 32'h0, 8'd6, rsp);
    chk_rsp("get_byte", rsp, 3'd1, 8'd6, 2'd2, 32'h00007700, 1'b0);

    xact(3'd4, 32'h40, 2'd2, 4'hF, 32'h0, 8'd7, rsp);
    chk_rsp("err_range", rsp, 3'd1, 8'd7, 2'd2, 32'h0, ERR_EXP);
    xact(3'd0, 32'h2, 2'd2, 4'hF, 32'hFFFFFFFF, 8'd8, rsp);
    chk_rsp("err_align", rsp, 3'd0, 8'd8, 2'd2, 32'h0, ERR_EXP);
    xact(3'd0, 32'h8, 2'd2, 4'h7, 32'hFFFFFFFF, 8'd9, rsp);
    chk_rsp("err_fullmask", rsp, 3'd0, 8'd9, 2'd2, 32'h0, ERR_EXP);
    xact(3'd1, 32'h8, 2'd2, 4'h0, 32'hFFFFFFFF, 8'd10, rsp);
    chk_rsp("err_zeromask", rsp, 3'd0, 8'd10, 2'd2, 32'h0, ERR_EXP);
    xact(3'd0, 32'h8, 2'd3, 4'hF, 32'hFFFFFFFF, 8'd11, rsp);
    chk_rsp("err_size", rsp, 3'd0, 8'd11, 2'd3, 32'h0, ERR_EXP);
    xact(3'd3, 32'h8, 2'd2, 4'hF, 32'hFFFFFFFF, 8'd12, rsp);
    chk_rsp("err_opcode", rsp, 3'd0, 8'd12, 2'd2, 32'h0, ERR_EXP);
    xact(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd13, rsp);
    chk_rsp("err_unchanged_w2", rsp, 3'd1, 8'd13, 2'd2, 32'hDEAABEEF, 1'b0);
    xact(3'd4, 32'h0, 2'd2, 4'hF, 32'h0, 8'd14, rsp);
    chk_rsp("err_unchanged_w0", rsp, 3'd1, 8'd14, 2'd2, 32'h0, 1'b0);
    tick();
    chk("idle_d_valid", 32'(tl_o.d_valid), 32'd0);

    // Back-pressure: one response held, a second request waiting behind it.
    tl_i.d_ready = 1'b0;
    drive(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd5);
    tick();
    drive(3'd4, 32'hC, 2'd2, 4'hF, 32'h0, 8'd6);
    for (int c = 0; c < 5; c++) begin
      chk("bp_a_ready", 32'(tl_o.a_ready), 32'd0);
      chk("bp_d_valid", 32'(tl_o.d_valid), 32'd1);
      chk("bp_d_data", tl_o.d_data, 32'hDEAABEEF);
      chk("bp_d_source", 32'(tl_o.d_source), 32'd5);
      tick();
    end
    tl_i.d_ready = 1'b1;
    #1;
    chk("bp_release_a_ready", 32'(tl_o.a_ready), 32'd1);
    @(posedge clk);
    #1;
    tl_i.a_valid = 1'b0;
    chk("bp_next_valid", 32'(tl_o.d_valid), 32'd1);
    chk("bp_next_source", 32'(tl_o.d_source), 32'd6);
    chk("bp_next_data", tl_o.d_data, 32'h00007700);
    tick();
    chk("bp_drain_valid", 32'(tl_o.d_valid), 32'd0);

    // Eight back-to-back Gets, one response per cycle.
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'd4, 32'(4 * i), 2'd2, 4'hF, 32'h0, 8'(16 + i));
      tick();
      chk("b2b_valid", 32'(tl_o.d_valid), 32'd1);
      chk("b2b_source", 32'(tl_o.d_source), 32'(16 + i));
      chk("b2b_data", tl_o.d_data, exp_word(i));
    end
    tl_i.a_valid = 1'b0;
    tick();
    chk("b2b_drain_valid", 32'(tl_o.d_valid), 32'd0);

    // Reset while a response is pending.
    tl_i.d_ready = 1'b0;
    drive(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd9);
    tick();
    tl_i.a_valid = 1'b0;
    chk("mid_pending_valid", 32'(tl_o.d_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(tl_o.d_valid), 32'd0);
    chk("mid_rst_data", tl_o.d_data, 32'h0);
    chk("mid_rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("no_replay_valid", 32'(tl_o.d_valid), 32'd0);
    xact(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd20, rsp);
    chk_rsp("post_rst_get", rsp, 3'd1, 8'd20, 2'd2, 32'h0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
